// File: rtl/sprite_row_fetcher.sv
// sprite_row_fetcher: read-side client of the registered sprite ROM.
// It accepts a (start address, row count) request, fetches consecutive rows
// and streams each row MSB-first as PIX_BITS-wide pixels with valid/ready.
// Optional build macro SPRITE_PREFETCH_EN: prefetches the next row into a
// holding register so the pixel stream runs across row boundaries without
// a bubble.
module sprite_row_fetcher #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 12,
  parameter int PIX_BITS   = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [CNT_WIDTH-1:0]  req_rows,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [PIX_BITS-1:0]   pix_data,
  output logic                  pix_eol,
  output logic                  pix_last,
  output logic                  busy,
  output logic                  done
);

  localparam int PIX_PER_ROW = DATA_WIDTH / PIX_BITS;
  localparam int PCW         = (PIX_PER_ROW > 1) ? $clog2(PIX_PER_ROW) : 1;
  localparam logic [PCW-1:0]        CNT_INIT = PCW'(PIX_PER_ROW - 1);
  localparam logic [PCW-1:0]        PCNT_ONE = PCW'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
`ifdef SPRITE_PREFETCH_EN
  localparam logic [CNT_WIDTH-1:0]  CNT_TWO  = CNT_WIDTH'(2);
`endif

  // ADDR lets the ROM sample rom_addr; LOAD captures its registered output.
  typedef enum logic [1:0] {IDLE, ADDR, LOAD, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [CNT_WIDTH-1:0]  rows_left_q, rows_left_d;  // rows not yet fully emitted
  logic [PCW-1:0]        pix_cnt_q, pix_cnt_d;      // pixels left in row minus one
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  done_q, done_d;

`ifdef SPRITE_PREFETCH_EN
  // At most one prefetch is in flight: pf_p0 = address just issued,
  // pf_p1 = rom_q carries the prefetched row this cycle.
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic                  pf_p0_q, pf_p0_d;
  logic                  pf_p1_q, pf_p1_d;
  logic                  pf_take;                   // rom_q consumed directly this cycle
`endif

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      rows_left_q <= '0;
      pix_cnt_q   <= '0;
      shreg_q     <= '0;
      done_q      <= 1'b0;
`ifdef SPRITE_PREFETCH_EN
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      pf_p0_q     <= 1'b0;
      pf_p1_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      rows_left_q <= rows_left_d;
      pix_cnt_q   <= pix_cnt_d;
      shreg_q     <= shreg_d;
      done_q      <= done_d;
`ifdef SPRITE_PREFETCH_EN
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      pf_p0_q     <= pf_p0_d;
      pf_p1_q     <= pf_p1_d;
`endif
    end
  end

  // Next-state logic: request intake, row fetch sequencing and pixel shifting.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    rows_left_d = rows_left_q;
    pix_cnt_d   = pix_cnt_q;
    shreg_d     = shreg_q;
    done_d      = 1'b0;
`ifdef SPRITE_PREFETCH_EN
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    pf_p0_d     = 1'b0;
    pf_p1_d     = pf_p0_q;
    pf_take     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_rows == '0) begin
            done_d = 1'b1;                        // empty request completes at once
          end else begin
            rom_addr_d  = req_addr;
            rows_left_d = req_rows;
            state_d     = ADDR;
          end
        end
      end
      ADDR: state_d = LOAD;
      LOAD: begin
        shreg_d   = rom_q;
        pix_cnt_d = CNT_INIT;
        state_d   = SHIFT;
`ifdef SPRITE_PREFETCH_EN
        pf_take = 1'b1;
        if (rows_left_q > CNT_ONE) begin
          rom_addr_d = rom_addr_q + ADDR_ONE;     // start fetching the next row now
          pf_p0_d    = 1'b1;
        end
`endif
      end
      SHIFT: begin
        if (pix_ready) begin
          shreg_d   = shreg_q << PIX_BITS;
          pix_cnt_d = pix_cnt_q - PCNT_ONE;
          if (pix_cnt_q == '0) begin
            if (rows_left_q > CNT_ONE) begin
              rows_left_d = rows_left_q - CNT_ONE;
`ifdef SPRITE_PREFETCH_EN
              if (hold_vld_q || pf_p1_q) begin
                // Next row already here (or arriving on rom_q): no bubble.
                shreg_d    = hold_vld_q ? hold_q : rom_q;
                pf_take    = 1'b1;
                hold_vld_d = 1'b0;
                pix_cnt_d  = CNT_INIT;
                if (rows_left_q > CNT_TWO) begin
                  rom_addr_d = rom_addr_q + ADDR_ONE;
                  pf_p0_d    = 1'b1;
                end
              end else begin
                state_d = LOAD;                   // very short rows: wait for the prefetch
              end
`else
              rom_addr_d = rom_addr_q + ADDR_ONE;
              state_d    = ADDR;
`endif
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SPRITE_PREFETCH_EN
    // Park the prefetched row if it was not consumed straight off rom_q.
    if (pf_p1_q && !pf_take) begin
      hold_d     = rom_q;
      hold_vld_d = 1'b1;
    end
`endif
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rom_addr  = rom_addr_q;
  assign pix_valid = (state_q == SHIFT);
  assign pix_data  = shreg_q[DATA_WIDTH-1 -: PIX_BITS];
  assign pix_eol   = pix_valid && (pix_cnt_q == '0);
  assign pix_last  = pix_eol && (rows_left_q == CNT_ONE);
  assign done      = done_q;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Testbench for sprite_row_fetcher: randomized requests against a
// behavioural ROM/pixel model with a queue-based scoreboard.
module tb_sprite_row_fetcher;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int PB = 1;
  localparam int CW = 8;
`ifdef SPRITE_PREFETCH_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 2;
`endif

  typedef struct {
    logic d;
    logic eol;
    logic last;
  } px_t;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [CW-1:0] req_rows;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic          pix_valid;
  logic          pix_ready;
  logic [PB-1:0] pix_data;
  logic          pix_eol;
  logic          pix_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] rom_mem [16];
  px_t           sb[$];
  int            errors;
  int            checks;
  int            done_cnt;
  int            ready_mode;
  int            pat [4];
  int            rdy_idx;
  bit            in_gap;
  int            gap;
  bit            prev_stall;
  px_t           prev;
  px_t           e;

  sprite_row_fetcher #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PIX_BITS(PB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_rows(req_rows),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_eol(pix_eol), .pix_last(pix_last),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered single-port ROM, one cycle read latency.
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pixel stream: each row word emitted MSB-first.
  task automatic push_expect(input logic [AW-1:0] a, input int rows);
    logic [DW-1:0] w;
    for (int r = 0; r < rows; r++) begin
      w = rom_mem[4'(a + r)];
      for (int b = DW - 1; b >= 0; b--)
        sb.push_back('{w[b], (b == 0), (b == 0) && (r == rows - 1)});
    end
  endtask

  // Consumer readiness pattern, changed just after each rising edge.
  initial begin
    pat = '{1, 0, 0, 1};
    rdy_idx = 0;
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: begin
          pix_ready = (pat[rdy_idx % 4] != 0);
          rdy_idx++;
        end
        default: pix_ready = ($urandom_range(0, 1) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted pixel, checks stall
  // stability, the inter-row gap and counts done pulses.
  initial begin
    in_gap = 0;
    gap = 0;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_gap = 0;
        prev_stall = 0;
      end else begin
        if (done) done_cnt++;
        if (in_gap) begin
          if (pix_valid) begin
            chk("row_gap", gap, EXP_GAP);
            in_gap = 0;
          end else begin
            gap++;
            if (gap > 20) begin
              chk("row_gap_timeout", gap, EXP_GAP);
              in_gap = 0;
            end
          end
        end
        if (prev_stall) begin
          chk("stall_valid", pix_valid, 1);
          chk("stall_data", pix_data, prev.d);
          chk("stall_eol", pix_eol, prev.eol);
          chk("stall_last", pix_last, prev.last);
        end
        prev_stall = pix_valid && !pix_ready;
        prev = '{pix_data[0], pix_eol, pix_last};
        if (pix_valid && pix_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_pixel: got data=%0b with empty scoreboard at %0t", pix_data, $time);
          end else begin
            e = sb.pop_front();
            chk("pix_data", pix_data, e.d);
            chk("pix_eol", pix_eol, e.eol);
            chk("pix_last", pix_last, e.last);
          end
          if (pix_eol && !pix_last) begin
            in_gap = 1;
            gap = 0;
          end
        end
      end
    end
  end

  task automatic run_req(input logic [AW-1:0] a, input int rows, input int mode, input bit poke);
    logic [AW-1:0] seen[$];
    logic [AW-1:0] addr0;
    int d0;
    int first_valid;
    bit got_done;
    ready_mode = mode;
    @(posedge clk);
    #1;
    chk("req_ready_idle", req_ready, 1);
    addr0 = rom_addr;
    req_valid = 1'b1;
    req_addr = a;
    req_rows = CW'(rows);
    push_expect(a, rows);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = 4'($urandom);
    req_rows = 8'($urandom);
    $display("req addr=%0d rows=%0d ready_mode=%0d", a, rows, mode);
    if (rows == 0) begin
      @(negedge clk);
      chk("zero_done", done, 1);
      chk("zero_pix_valid", pix_valid, 0);
      chk("zero_rom_addr", rom_addr, addr0);
      chk("zero_req_ready", req_ready, 1);
      @(negedge clk);
      chk("zero_done_width", done, 0);
      chk("zero_pix_valid2", pix_valid, 0);
      chk("zero_done_count", done_cnt, d0 + 1);
      return;
    end
    first_valid = 0;
    got_done = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (poke && c == 1) begin
        req_valid = 1'b1;
        req_addr = 4'd7;
        req_rows = 8'd5;
      end
      if (poke && c <= 4) chk("busy_req_ready", req_ready, 0);
      if (poke && c == 5) req_valid = 1'b0;
      if (busy && (seen.size() == 0 || seen[$] != rom_addr)) seen.push_back(rom_addr);
      if (first_valid == 0 && pix_valid) first_valid = c;
      if (done) begin
        got_done = 1;
        break;
      end
    end
    chk("first_pixel_latency", first_valid, 3);
    chk("done_seen", got_done, 1);
    chk("done_pix_valid", pix_valid, 0);
    chk("done_busy", busy, 0);
    chk("sb_drained", sb.size(), 0);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("done_count", done_cnt, d0 + 1);
    chk("rom_addr_seq_len", seen.size(), rows);
    for (int i = 0; i < rows && i < seen.size(); i++)
      chk("rom_addr_seq", seen[i], 4'(a + i));
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    errors = 0;
    checks = 0;
    done_cnt = 0;
    ready_mode = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_rows = '0;
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'($urandom);
    rom_mem[0]  = 8'h01;
    rom_mem[3]  = 8'hA5;
    rom_mem[4]  = 8'h3C;
    rom_mem[15] = 8'hFF;
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_eol", pix_eol, 0);
    chk("rst_pix_last", pix_last, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    run_req(4'd3, 1, 0, 0);
    run_req(4'd3, 2, 0, 1);
    run_req(4'd3, 2, 1, 0);
    run_req(4'd15, 2, 0, 0);
    run_req(4'd5, 0, 0, 0);

    // Reset in the middle of the first row of a two-row request.
    ready_mode = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr = 4'd3;
    req_rows = 8'd2;
    push_expect(4'd3, 2);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    $display("req addr=3 rows=2 with reset mid-row");
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pix_valid", pix_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pix_data", pix_data, 0);
    chk("midrst_pix_eol", pix_eol, 0);
    chk("midrst_pix_last", pix_last, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);
    run_req(4'd3, 2, 0, 0);

    for (int k = 0; k < 12; k++)
      run_req(4'($urandom_range(0, 15)), $urandom_range(1, 3), $urandom_range(0, 2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
